// File: rtl/image_word_unpacker.sv
// Unpacks 128-bit image words (four 24-bit RGB lanes) into a one-pixel-per-cycle
// AXI-stream with start-of-frame/end-of-line tags, frame position and an underrun flag.
module image_word_unpacker #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic         s_axi_aclk,
    input  logic         s_axi_aresetn,
    input  logic         enable,
    input  logic [127:0] s_word_tdata,
    input  logic         s_word_tvalid,
    output logic         s_word_tready,
    output logic [23:0]  m_pix_tdata,
    output logic         m_pix_tvalid,
    input  logic         m_pix_tready,
    output logic         m_pix_tuser,
    output logic         m_pix_tlast,
    output logic         frame_done,
    output logic         underrun,
    input  logic         underrun_clr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [127:0]   r_hold_data;
    logic [1:0]     r_lane;
    logic [10:0]    r_x;
    logic [10:0]    r_y;
    logic           r_frame_done;
    logic           r_underrun;

    logic           w_hold_valid;
    logic           w_pix_hs;
    logic           w_word_acc;
    logic           w_x_end;
    logic           w_y_end;
    logic           w_underrun_set;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else if (w_word_acc) begin
            w_state_next = ST_EMIT;
        end else if (w_pix_hs && r_lane == 2'd3) begin
            w_state_next = ST_IDLE;
        end
    end

    always_comb begin
        w_hold_valid  = (r_state == ST_EMIT);
        m_pix_tvalid  = w_hold_valid;
        w_pix_hs      = w_hold_valid && m_pix_tready;
        // Refill on the same edge the last lane leaves, so words stream with no bubble.
        s_word_tready = enable && (!w_hold_valid || (r_lane == 2'd3 && w_pix_hs));
        w_word_acc    = s_word_tvalid && s_word_tready;
        m_pix_tdata   = r_hold_data[{r_lane, 5'd0} +: 24];
        w_x_end       = (r_x == 11'(H_ACTIVE - 1));
        w_y_end       = (r_y == 11'(V_ACTIVE - 1));
        m_pix_tuser   = (r_x == 11'd0) && (r_y == 11'd0);
        m_pix_tlast   = w_x_end;
    end

    // NOTE: the holding register is reset because m_pix_tdata must read 0 out of reset.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_hold_data  <= '0;
            r_lane       <= 2'd0;
            r_x          <= 11'd0;
            r_y          <= 11'd0;
            r_frame_done <= 1'b0;
        end else if (!enable) begin
            r_lane       <= 2'd0;
            r_x          <= 11'd0;
            r_y          <= 11'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pix_hs && w_x_end && w_y_end;
            if (w_word_acc) begin
                r_hold_data <= s_word_tdata;
                r_lane      <= 2'd0;
            end else if (w_pix_hs) begin
                r_lane <= r_lane + 2'd1;
            end
            if (w_pix_hs) begin
                if (w_x_end) begin
                    r_x <= 11'd0;
                    r_y <= w_y_end ? 11'd0 : r_y + 11'd1;
                end else begin
                    r_x <= r_x + 11'd1;
                end
            end
        end
    end

    // Starvation only counts mid-frame; a set in the same cycle as a clear wins.
    assign w_underrun_set = enable && !w_hold_valid && ((r_x != 11'd0) || (r_y != 11'd0));

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_image_word_unpacker.sv
// Randomized self-checking bench for image_word_unpacker, using a small frame and a
// queue-based model of pending pixels and linear frame position.
module tb_image_word_unpacker;

    localparam int H = 16;
    localparam int V = 4;
    localparam int F = H * V;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [127:0] s_word_tdata;
    logic         s_word_tvalid;
    logic         s_word_tready;
    logic [23:0]  m_pix_tdata;
    logic         m_pix_tvalid;
    logic         m_pix_tready;
    logic         m_pix_tuser;
    logic         m_pix_tlast;
    logic         frame_done;
    logic         underrun;
    logic         underrun_clr;

    always #5 clk = ~clk;

    image_word_unpacker #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .enable        (enable),
        .s_word_tdata  (s_word_tdata),
        .s_word_tvalid (s_word_tvalid),
        .s_word_tready (s_word_tready),
        .m_pix_tdata   (m_pix_tdata),
        .m_pix_tvalid  (m_pix_tvalid),
        .m_pix_tready  (m_pix_tready),
        .m_pix_tuser   (m_pix_tuser),
        .m_pix_tlast   (m_pix_tlast),
        .frame_done    (frame_done),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_tlast_seen;
    int n_fd_seen;

    // Reference model: pixels still owed from accepted words, and linear position in frame.
    logic [23:0] q[$];
    int          pos;
    logic        exp_ur;
    logic        exp_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk_word(input int base);
        logic [127:0] w;
        for (int k = 0; k < 4; k++) begin
            w[32*k +: 32] = {8'($urandom), 24'(base + k)};
        end
        return w;
    endfunction

    function automatic logic [127:0] rand_word();
        logic [127:0] w;
        for (int k = 0; k < 4; k++) begin
            w[32*k +: 32] = $urandom;
        end
        return w;
    endfunction

    // Called at a falling edge: drive, check outputs, advance the model, wait for next falling edge.
    task automatic step(input logic en, input logic v, input logic [127:0] d,
                        input logic rdy, input logic clr, output logic acc);
        logic exp_tvalid;
        logic exp_tready;
        logic hs_pix;
        logic set;
        enable        = en;
        s_word_tvalid = v;
        s_word_tdata  = d;
        m_pix_tready  = rdy;
        underrun_clr  = clr;
        #1;
        exp_tvalid = (q.size() != 0);
        exp_tready = en && (q.size() == 0 || (q.size() == 1 && rdy));
        check("tvalid", 32'(m_pix_tvalid), 32'(exp_tvalid));
        check("s_tready", 32'(s_word_tready), 32'(exp_tready));
        check("underrun", 32'(underrun), 32'(exp_ur));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        if (exp_tvalid) begin
            check("tdata", 32'(m_pix_tdata), 32'(q[0]));
            check("tuser", 32'(m_pix_tuser), 32'(pos == 0));
            check("tlast", 32'(m_pix_tlast), 32'(pos % H == H - 1));
        end
        if (m_pix_tvalid && m_pix_tlast && rdy) n_tlast_seen++;
        if (frame_done) n_fd_seen++;
        acc    = v && exp_tready;
        hs_pix = exp_tvalid && rdy;
        set    = en && (q.size() == 0) && (pos != 0);
        exp_ur = set ? 1'b1 : (clr ? 1'b0 : exp_ur);
        exp_fd = 1'b0;
        if (!en) begin
            q.delete();
            pos = 0;
        end else begin
            if (hs_pix) begin
                void'(q.pop_front());
                if (pos == F - 1) exp_fd = 1'b1;
                pos = (pos + 1) % F;
            end
            if (acc) begin
                for (int k = 0; k < 4; k++) q.push_back(d[32*k +: 24]);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(m_pix_tvalid), 32'd0);
        check({tag, "_tdata"}, 32'(m_pix_tdata), 32'd0);
        check({tag, "_tuser"}, 32'(m_pix_tuser), 32'd1);
        check({tag, "_tlast"}, 32'(m_pix_tlast), 32'd0);
        check({tag, "_fd"}, 32'(frame_done), 32'd0);
        check({tag, "_ur"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         acc;
        logic [127:0] w;
        int           base;
        int           words;
        int           guard;
        logic         ur_saved;

        rst_n = 1'b0;
        enable = 1'b0;
        s_word_tdata = '0;
        s_word_tvalid = 1'b0;
        m_pix_tready = 1'b0;
        underrun_clr = 1'b0;
        pos = 0;
        exp_ur = 1'b0;
        exp_fd = 1'b0;
        n_tlast_seen = 0;
        n_fd_seen = 0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_s_tready", 32'(s_word_tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word: four lanes in order, then starvation at x=4.
        w = {32'hFF778899, 32'h00445566, 32'h5A112233, 32'h00AABBCC};
        step(1'b1, 1'b1, w, 1'b1, 1'b0, acc);
        repeat (6) step(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);
        check("single_ur", 32'(underrun), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

        // Two back-to-back frames with incrementing pixel index.
        n_tlast_seen = 0;
        n_fd_seen = 0;
        base = 0;
        w = mk_word(base);
        for (int i = 0; i < 2 * F + 8; i++) begin
            step(1'b1, 1'b1, w, 1'b1, 1'b0, acc);
            if (acc) begin
                base += 4;
                w = mk_word(base);
            end
        end
        check("tlast_count", 32'(n_tlast_seen), 32'(2 * V));
        check("frame_done_count", 32'(n_fd_seen), 32'd2);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

        // Random backpressure over 64 words; source never starves.
        words = 0;
        guard = 0;
        w = rand_word();
        while (words < 64 && guard < 2000) begin
            step(1'b1, 1'b1, w, 1'($urandom_range(0, 1)), 1'b0, acc);
            guard++;
            if (acc) begin
                words++;
                w = rand_word();
            end
        end
        check("bp_words", 32'(words), 32'd64);
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            step(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);
            guard++;
        end
        check("bp_drained", 32'(q.size()), 32'd0);
        check("bp_ur", 32'(underrun), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

        // Underrun sticky: starve mid-frame, clear during stall loses, clear after resume wins.
        words = 0;
        guard = 0;
        w = rand_word();
        while (words < 2 && guard < 50) begin
            step(1'b1, 1'b1, w, 1'b1, 1'b0, acc);
            guard++;
            if (acc) begin
                words++;
                w = rand_word();
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0, 1'b1, 1'(i == 7), acc);
        end
        check("ur_sticky", 32'(underrun), 32'd1);
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 10) begin
            step(1'b1, 1'b1, w, 1'b1, 1'b0, acc);
            guard++;
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, acc);
        check("ur_cleared", 32'(underrun), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

        // Abort at x=2, y=3 with a word held.
        guard = 0;
        base = 0;
        w = mk_word(base);
        while (pos != 3 * H + 2 && guard < 200) begin
            step(1'b1, 1'b1, w, 1'b1, 1'b0, acc);
            guard++;
            if (acc) begin
                base += 4;
                w = mk_word(base);
            end
        end
        check("abort_pos_reached", 32'(pos), 32'(3 * H + 2));
        ur_saved = exp_ur;
        step(1'b0, 1'b1, w, 1'b1, 1'b0, acc);
        check("abort_tvalid", 32'(m_pix_tvalid), 32'd0);
        check("abort_s_tready", 32'(s_word_tready), 32'd0);
        step(1'b0, 1'b1, w, 1'b1, 1'b0, acc);
        w = mk_word(24'h100);
        step(1'b1, 1'b1, w, 1'b1, 1'b0, acc);
        check("restart_tuser", 32'(m_pix_tuser), 32'd1);
        check("restart_tdata", 32'(m_pix_tdata), 32'h100);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);
        check("abort_ur_kept", 32'(underrun), 32'(ur_saved));
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

        // Async reset asserted between edges while emitting.
        base = 0;
        w = mk_word(base);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, w, 1'b1, 1'b0, acc);
            if (acc) begin
                base += 4;
                w = mk_word(base);
            end
        end
        check("pre_reset_tvalid", 32'(m_pix_tvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q.delete();
        pos = 0;
        exp_ur = 1'b0;
        exp_fd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = 0;
        w = mk_word(base);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, w, 1'b1, 1'b0, acc);
            if (acc) begin
                base += 4;
                w = mk_word(base);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
